// File: rtl/cpu_pkg.sv
// Shared shift-controller definitions: shift-register commands, R-type
// function codes and the controller state encoding.
package cpu_pkg;

  typedef enum logic [2:0] {
    SC_NOP  = 3'b000,
    SC_LOAD = 3'b001,
    SC_SLL  = 3'b010,
    SC_SRL  = 3'b011,
    SC_SRA  = 3'b100
  } shift_cmd_e;

  localparam logic [5:0] FUNCT_SLL  = 6'h00;
  localparam logic [5:0] FUNCT_SRL  = 6'h02;
  localparam logic [5:0] FUNCT_SRA  = 6'h03;
  localparam logic [5:0] FUNCT_SLLV = 6'h04;
  localparam logic [5:0] FUNCT_SRLV = 6'h06;
  localparam logic [5:0] FUNCT_SRAV = 6'h07;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_SHIFT   = 2'd2,
    ST_CAPTURE = 2'd3
  } state_e;

endpackage

// File: rtl/shift_ctrl_decode.sv
// Combinational R-type function decode: shift command, whether the amount
// comes from Rs (variable form) and whether the function code is a shift.
module shift_ctrl_decode
  import cpu_pkg::*;
(
  input  logic [5:0] funct,
  output shift_cmd_e op,
  output logic       var_amt,
  output logic       legal
);

  // Map each shift function code onto its command; anything else is illegal
  always_comb begin
    op      = SC_NOP;
    var_amt = 1'b0;
    legal   = 1'b1;
    case (funct)
      FUNCT_SLL:  op = SC_SLL;
      FUNCT_SRL:  op = SC_SRL;
      FUNCT_SRA:  op = SC_SRA;
      FUNCT_SLLV: begin op = SC_SLL; var_amt = 1'b1; end
      FUNCT_SRLV: begin op = SC_SRL; var_amt = 1'b1; end
      FUNCT_SRAV: begin op = SC_SRA; var_amt = 1'b1; end
      default:    legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/shift_ctrl.sv
// Shift controller: sequences an external shift register through
// load / shift / capture for one R-type shift instruction.
// Optional feature macro SHIFT_CTRL_ILLEGAL_TRAP_EN: when defined, an
// unlisted function code skips load/shift, keeps Result and flags Err.
module shift_ctrl
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int AMT_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Start,
  input  logic [5:0]        Funct,
  input  logic [4:0]        Shamt,
  input  logic [DATA_W-1:0] Rs_value,
  input  logic [DATA_W-1:0] Rt_value,
  input  logic [DATA_W-1:0] Shift_reg_out,
  output logic [2:0]        ShiftControl,
  output logic [DATA_W-1:0] Shift_source,
  output logic [DATA_W-1:0] Shift_amount,
  output logic [DATA_W-1:0] Result,
  output logic              Busy,
  output logic              Done,
  output logic              Err
);

  state_e              state_q, state_d;
  shift_cmd_e          dec_op, op_q;
  logic                dec_var, dec_legal;
  logic [AMT_W-1:0]    new_amt, amt_q;
  logic [DATA_W-1:0]   rt_q, result_q;
  logic                done_q;
  logic                accept;

  shift_ctrl_decode u_decode (
    .funct   (Funct),
    .op      (dec_op),
    .var_amt (dec_var),
    .legal   (dec_legal)
  );

  assign accept  = (state_q == ST_IDLE) && Start;
  assign new_amt = dec_var ? Rs_value[AMT_W-1:0] : AMT_W'(Shamt);

`ifdef SHIFT_CTRL_ILLEGAL_TRAP_EN
  logic illegal_q;
  logic err_q;
  logic unused_rs;
  assign unused_rs = ^Rs_value[DATA_W-1:AMT_W];
`else
  logic unused_bits;
  assign unused_bits = ^{Rs_value[DATA_W-1:AMT_W], dec_legal};
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state sequencing; Start only matters while idle
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
`ifdef SHIFT_CTRL_ILLEGAL_TRAP_EN
          state_d = dec_legal ? ST_LOAD : ST_CAPTURE;
`else
          state_d = ST_LOAD;
`endif
        end
      end
      ST_LOAD:    state_d = ST_SHIFT;
      ST_SHIFT:   state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Command and operand outputs to the shift register
  always_comb begin
    ShiftControl = SC_NOP;
    Shift_source = '0;
    Shift_amount = '0;
    Busy         = 1'b0;
    case (state_q)
      ST_LOAD: begin
        ShiftControl = SC_LOAD;
        Shift_source = rt_q;
        Shift_amount = DATA_W'(amt_q);
        Busy         = 1'b1;
      end
      ST_SHIFT: begin
        ShiftControl = op_q;
        Shift_source = rt_q;
        Shift_amount = DATA_W'(amt_q);
        Busy         = 1'b1;
      end
      ST_CAPTURE: Busy = 1'b1;
      default: ;
    endcase
  end

  // Latch the operation on acceptance so later input changes are ignored
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rt_q      <= '0;
      amt_q     <= '0;
      op_q      <= SC_NOP;
`ifdef SHIFT_CTRL_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else if (accept) begin
      rt_q      <= Rt_value;
      amt_q     <= new_amt;
      op_q      <= dec_op;
`ifdef SHIFT_CTRL_ILLEGAL_TRAP_EN
      illegal_q <= !dec_legal;
`endif
    end
  end

  // Capture the shifted value and raise Done for the following cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result_q <= '0;
      done_q   <= 1'b0;
`ifdef SHIFT_CTRL_ILLEGAL_TRAP_EN
      err_q    <= 1'b0;
`endif
    end else begin
      done_q <= (state_q == ST_CAPTURE);
`ifdef SHIFT_CTRL_ILLEGAL_TRAP_EN
      err_q  <= (state_q == ST_CAPTURE) && illegal_q;
      if ((state_q == ST_CAPTURE) && !illegal_q) result_q <= Shift_reg_out;
`else
      if (state_q == ST_CAPTURE) result_q <= Shift_reg_out;
`endif
    end
  end

  assign Result = result_q;
  assign Done   = done_q;
`ifdef SHIFT_CTRL_ILLEGAL_TRAP_EN
  assign Err    = err_q;
`else
  assign Err    = 1'b0;
`endif

endmodule
